// File: rtl/rom_dl_arbiter.sv
// rom_dl_arbiter: shares the program-ROM RAM port between the HPS ioctl download
// writer and the game CPU read path. Download writes are buffered in a small FIFO,
// the CPU is held in reset while a ROM download runs, and reset is released a fixed
// number of cycles after the FIFO has drained.
//
// Optional build macro: ROM_CKSUM_EN adds output dl_cksum (16-bit wrapping sum of
// every byte written to RAM since the last DL entry).
//
// Ports:
//   clk_12, reset        clock, synchronous active-high reset
//   ioctl_*              HPS download interface (index 0 is the ROM)
//   cpu_rd, cpu_addr     CPU read request / address
//   test_stall           blocks FIFO pops (bring-up / test only, tie to 0 in a system)
//   cpu_dv               read data valid at RAM output, one cycle after mem_addr update
//   cpu_reset            CPU reset request
//   mem_addr/din/we      RAM port
//   dl_overflow          sticky: a ROM byte was dropped on a full FIFO
//   dl_busy              high while downloading or draining
module rom_dl_arbiter #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [15:0] ROM_SIZE   = 16'hC000,
  parameter int unsigned RST_HOLD   = 64
) (
  input  logic        clk_12,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        cpu_rd,
  input  logic [15:0] cpu_addr,
  input  logic        test_stall,
  output logic        cpu_dv,
  output logic        cpu_reset,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_din,
  output logic        mem_we,
  output logic        dl_overflow,
`ifdef ROM_CKSUM_EN
  output logic [15:0] dl_cksum,
`endif
  output logic        dl_busy
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {StRun, StDl, StDrain, StHold} state_e;

  logic [15:0]   fifo_addr_q [FIFO_DEPTH];
  logic [7:0]    fifo_data_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  state_e      state_q, state_d;
  logic [15:0] hold_q, hold_d;
  logic        rd_pend_q;

  logic        dl_req, dl_entry, push_req, fifo_empty, fifo_full;
  logic        rd_grant, issue_wr, pop, bypass, enq, drop;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;

  always_comb begin
    dl_req     = ioctl_download && (ioctl_index == 8'd0);
    dl_entry   = dl_req && (state_q != StDl);
    push_req   = ioctl_wr && dl_req && (ioctl_addr[24:16] == 9'd0) &&
                 (ioctl_addr[15:0] < ROM_SIZE);
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CW'(FIFO_DEPTH));
    rd_grant   = cpu_rd && (state_q == StRun);
    // An empty FIFO forwards the incoming byte directly for one-cycle write latency.
    issue_wr   = (!fifo_empty || push_req) && !rd_grant && !test_stall;
    pop        = issue_wr && !fifo_empty;
    bypass     = issue_wr && fifo_empty;
    // A pop in the same cycle frees a slot, so a push on a full FIFO still lands.
    enq        = push_req && !bypass && (!fifo_full || pop);
    drop       = push_req && fifo_full && !pop;
    wr_addr    = fifo_empty ? ioctl_addr[15:0] : fifo_addr_q[rd_ptr_q];
    wr_data    = fifo_empty ? ioctl_dout : fifo_data_q[rd_ptr_q];
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (dl_req) begin
      state_d = StDl;
    end else begin
      case (state_q)
        StDl:    if (!ioctl_download) state_d = StDrain;
        StDrain: if (fifo_empty && !issue_wr) begin
          state_d = StHold;
          hold_d  = 16'(RST_HOLD);
        end
        StHold:  if (hold_q <= 16'd1) state_d = StRun;
                 else hold_d = hold_q - 16'd1;
        default: ;
      endcase
    end
  end

  // FSM, FIFO control and memory port.
  always_ff @(posedge clk_12) begin
    if (reset) begin
      state_q     <= StHold;
      hold_q      <= 16'(RST_HOLD);
      cpu_reset   <= 1'b1;
      dl_busy     <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      mem_addr    <= '0;
      mem_din     <= '0;
      mem_we      <= 1'b0;
      rd_pend_q   <= 1'b0;
      cpu_dv      <= 1'b0;
      dl_overflow <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      cpu_reset <= (state_d != StRun);
      dl_busy   <= (state_d == StDl) || (state_d == StDrain);

      if (enq) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(enq) - CW'(pop);

      rd_pend_q <= rd_grant;
      cpu_dv    <= rd_pend_q;
      if (rd_grant) begin
        mem_addr <= cpu_addr;
        mem_we   <= 1'b0;
      end else if (issue_wr) begin
        mem_addr <= wr_addr;
        mem_din  <= wr_data;
        mem_we   <= 1'b1;
      end else begin
        mem_we   <= 1'b0;
      end

      if (drop)          dl_overflow <= 1'b1;
      else if (dl_entry) dl_overflow <= 1'b0;
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk_12) begin
    if (!reset && enq) begin
      fifo_addr_q[wr_ptr_q] <= ioctl_addr[15:0];
      fifo_data_q[wr_ptr_q] <= ioctl_dout;
    end
  end

`ifdef ROM_CKSUM_EN
  logic [15:0] cksum_q;
  always_ff @(posedge clk_12) begin
    if (reset || dl_entry) cksum_q <= '0;
    else if (mem_we)       cksum_q <= cksum_q + {8'd0, mem_din};
  end
  assign dl_cksum = cksum_q;
`endif

endmodule
